// File: rtl/wb_crc32_master.sv
// Wishbone B4 classic initiator for the CRC32 register slave: soft reset,
// stream len words into the data register, then read the CRC back.
module wb_crc32_master #(
  parameter int          WB_AW    = 32,
  parameter int          WB_DW    = 32,
  parameter logic [31:0] CRC_BASE = 32'h0,
  parameter int          LEN_W    = 16,
  parameter int          RD_GAP   = 2,
  parameter int          TIMEOUT  = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      crc_o,
  output logic             err_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic [2:0]       wbm_cti_o,
  output logic [1:0]       wbm_bte_o,
  input  logic [WB_DW-1:0] wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (RD_GAP > 1) ? $clog2(RD_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RST_REQ, S_GAP, S_WR_WAIT, S_WR_REQ, S_RD_GAP, S_RD_REQ, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q;
  logic [TW-1:0]    tmo_q;
  logic [GW-1:0]    gap_q;
  logic [31:0]      dat_q, crc_q;
  logic             err_q;
  logic             in_req, bus_ack, bus_err, tmo_hit;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Bus outputs are decoded from the state flop, so an async reset drops cyc/stb at once.
  always_comb begin
    in_req  = (state_q == S_RST_REQ) || (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
    bus_err = in_req && wbm_err_i;
    bus_ack = in_req && wbm_ack_i && !wbm_err_i;
    tmo_hit = in_req && !wbm_ack_i && !wbm_err_i && (tmo_q == TW'(TIMEOUT - 1));
    state_d   = state_q;
    wbm_adr_o = '0;
    wbm_we_o  = 1'b0;
    unique case (state_q)
      S_IDLE:    if (start_i) state_d = S_RST_REQ;
      S_RST_REQ: begin
        wbm_adr_o = WB_AW'(CRC_BASE + 32'h8);
        wbm_we_o  = 1'b1;
      end
      S_WR_REQ: begin
        wbm_adr_o = WB_AW'(CRC_BASE);
        wbm_we_o  = 1'b1;
      end
      S_RD_REQ:  wbm_adr_o = WB_AW'(CRC_BASE + 32'h4);
      S_GAP:     state_d = (rem_q != '0) ? S_WR_WAIT : S_RD_GAP;
      S_WR_WAIT: if (s_valid_i) state_d = S_WR_REQ;
      S_RD_GAP:  if (gap_q == GW'(RD_GAP - 1)) state_d = S_RD_REQ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (bus_err || tmo_hit)  state_d = S_DONE;
    else if (bus_ack)        state_d = (state_q == S_RD_REQ) ? S_DONE : S_GAP;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rem_q <= '0;
      tmo_q <= '0;
      gap_q <= '0;
      dat_q <= '0;
      crc_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (in_req && !wbm_ack_i && !wbm_err_i) ? tmo_q + 1'b1 : '0;
      gap_q <= (state_q == S_RD_GAP) ? gap_q + 1'b1 : '0;
      if (state_q == S_IDLE && start_i) begin
        rem_q <= len_i;
        err_q <= 1'b0;
        crc_q <= '0;
        dat_q <= 32'h1;  // soft-reset command word
      end
      if (state_q == S_WR_WAIT && s_valid_i) dat_q <= s_data_i;
      if (state_q == S_WR_REQ && bus_ack)    rem_q <= rem_q - 1'b1;
      if (state_q == S_RD_REQ && bus_ack)    crc_q <= wbm_dat_i[31:0];
      if (bus_err || tmo_hit) begin
        err_q <= 1'b1;
        crc_q <= '0;
      end
    end
  end

  assign wbm_cyc_o = in_req;
  assign wbm_stb_o = in_req;
  assign wbm_dat_o = WB_DW'(dat_q);
  assign wbm_sel_o = 4'hF;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign s_ready_o = (state_q == S_WR_WAIT);
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign crc_o     = crc_q;
  assign err_o     = err_q;
endmodule

// File: tb/tb_wb_crc32_master.sv
// Randomized bench for wb_crc32_master: reactive CRC slave model plus a
// reference CRC-32 over the words offered to the stream.
module tb_wb_crc32_master;
  logic        wb_clk_i = 1'b0, wb_rst_n_i = 1'b0;
  logic        start_i = 1'b0, s_valid_i = 1'b0, s_ready_o, busy_o, done_o, err_o;
  logic [15:0] len_i = '0;
  logic [31:0] s_data_i = '0, crc_o, wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;

  wb_crc32_master dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .start_i(start_i), .len_i(len_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .busy_o(busy_o),
    .done_o(done_o), .crc_o(crc_o), .err_o(err_o), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0, errors = 0;
  logic [31:0] exp_words[$];
  logic [31:0] log_adr[$], log_dat[$];
  logic        log_we[$];
  int          sl_mode = 0, sl_err_at = 0, sl_dwr = 0;
  logic [31:0] sl_crc = 32'hFFFF_FFFF;
  bit          dw;

  // Reflected CRC-32 of one word, bytes consumed little-endian, LSB first.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r = c;
    for (int i = 0; i < 32; i++) r = (r[0] ^ w[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] model_crc();
    logic [31:0] r = 32'hFFFF_FFFF;
    foreach (exp_words[i]) r = crc_upd(r, exp_words[i]);
    return ~r;
  endfunction

  // Count of bus-log entries that differ from: reset write, n data writes, optional CRC read.
  function automatic int log_bad(input int n_data, input bit with_read);
    int bad = 0;
    int n   = 1 + n_data + (with_read ? 1 : 0);
    if (log_adr.size() != n) return 1000 + log_adr.size();
    if (log_we[0] !== 1'b1 || log_adr[0] !== 32'h8 || log_dat[0] !== 32'h1) bad++;
    for (int i = 1; i <= n_data; i++)
      if (log_we[i] !== 1'b1 || log_adr[i] !== 32'h0 || log_dat[i] !== exp_words[i-1]) bad++;
    if (with_read && (log_we[n-1] !== 1'b0 || log_adr[n-1] !== 32'h4)) bad++;
    return bad;
  endfunction

  // Slave: one-cycle registered ack; mode 1 errs on data write #sl_err_at,
  // mode 2 never responds, mode 3 never responds to data writes.
  always @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
      wbm_dat_i <= '0;
    end else begin
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) begin
        dw = wbm_we_o && (wbm_adr_o == 32'h0);
        if (sl_mode == 1 && dw && sl_dwr + 1 == sl_err_at) begin
          wbm_err_i <= 1'b1;
          sl_dwr++;
        end else if (!(sl_mode == 2 || (sl_mode == 3 && dw))) begin
          wbm_ack_i <= 1'b1;
          log_adr.push_back(wbm_adr_o); log_dat.push_back(wbm_dat_o); log_we.push_back(wbm_we_o);
          if (!wbm_we_o) wbm_dat_i <= ~sl_crc;
          else if (wbm_adr_o == 32'h8) sl_crc = 32'hFFFF_FFFF;
          else if (wbm_adr_o == 32'h0) begin
            sl_crc = crc_upd(sl_crc, wbm_dat_o);
            sl_dwr++;
          end
        end
      end
    end
  end

  // Protocol monitor: drop after ack/err, request stability, fixed sel/cti/bte, stb run length.
  int viol = 0, run = 0, last_run = 0;
  logic        p_ae = 1'b0, p_cyc = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = '0, p_dat = '0;
  always @(negedge wb_clk_i) begin
    if (p_ae && wbm_cyc_o) viol++;
    if (wbm_cyc_o && p_cyc && !p_ae &&
        (wbm_adr_o != p_adr || wbm_we_o != p_we || (wbm_we_o && wbm_dat_o != p_dat))) viol++;
    if (wbm_cyc_o && (wbm_stb_o !== 1'b1 || wbm_sel_o !== 4'hF)) viol++;
    if (wbm_cti_o !== 3'b000 || wbm_bte_o !== 2'b00) viol++;
    if (wbm_cyc_o) run++;
    else if (run != 0) begin last_run = run; run = 0; end
    p_ae = wbm_ack_i || wbm_err_i; p_cyc = wbm_cyc_o; p_we = wbm_we_o;
    p_adr = wbm_adr_o; p_dat = wbm_dat_o;
  end

  task automatic run_job(input int len, input bit toggle, input bit zero_w, output int done_cnt);
    bit job_over = 0;
    int idx = 0, ncyc = 0;
    bit ph = 1;
    exp_words.delete(); log_adr.delete(); log_dat.delete(); log_we.delete(); sl_dwr = 0;
    for (int i = 0; i < len; i++) exp_words.push_back(zero_w ? 32'h0 : $urandom);
    done_cnt = 0;
    @(negedge wb_clk_i); start_i = 1'b1; len_i = 16'(len);
    @(negedge wb_clk_i); start_i = 1'b0;
    fork
      begin
        while (idx < len && !job_over) begin
          @(negedge wb_clk_i);
          s_valid_i = toggle ? ph : 1'b1; ph = !ph;
          s_data_i  = exp_words[idx];
          if (s_valid_i && s_ready_o) idx++;
        end
        @(negedge wb_clk_i); s_valid_i = 1'b0;
      end
      begin
        while (!job_over && ncyc < 3000) begin
          @(negedge wb_clk_i); ncyc++;
          if (done_o) begin done_cnt++; job_over = 1; end
        end
        job_over = 1;
        @(negedge wb_clk_i);
        if (done_o) done_cnt++;
      end
    join
  endtask

  task automatic test_reset();
    repeat (3) @(negedge wb_clk_i);
    checks++; if ({busy_o, done_o, err_o, s_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000", {busy_o, done_o, err_o, s_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
    checks++; if ({crc_o, wbm_adr_o, wbm_dat_o} !== 96'h0) begin
      errors++; $display("FAIL reset_data: crc %h adr %h dat %h want 0", crc_o, wbm_adr_o, wbm_dat_o); end
    wb_rst_n_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    checks++; if (busy_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy %b cyc %b want 0 0", busy_o, wbm_cyc_o); end
  endtask

  task automatic test_single_zero();
    int dc;
    viol = 0; sl_mode = 0;
    run_job(1, 1'b0, 1'b1, dc);
    checks++; if (crc_o !== 32'h2144_DF1C) begin errors++; $display("FAIL single_crc: got %h want 2144df1c", crc_o); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL single_done: %0d pulse cycles want 1", dc); end
    checks++; if (log_bad(1, 1'b1) !== 0) begin errors++; $display("FAIL single_bus: %0d bad entries want 0", log_bad(1, 1'b1)); end
    checks++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL single_end: err %b busy %b want 0 0", err_o, busy_o); end
  endtask

  task automatic test_stream_toggle();
    int dc;
    viol = 0; sl_mode = 0;
    run_job(4, 1'b1, 1'b0, dc);
    checks++; if (crc_o !== model_crc()) begin errors++; $display("FAIL toggle_crc: got %h want %h", crc_o, model_crc()); end
    checks++; if (log_bad(4, 1'b1) !== 0) begin errors++; $display("FAIL toggle_bus: %0d bad entries want 0", log_bad(4, 1'b1)); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL toggle_done: %0d pulse cycles want 1", dc); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL toggle_protocol: %0d violations want 0", viol); end
  endtask

  task automatic test_len0();
    int dc;
    sl_mode = 0;
    run_job(0, 1'b0, 1'b0, dc);
    checks++; if (crc_o !== 32'h0 || err_o !== 1'b0) begin errors++; $display("FAIL len0_result: crc %h err %b want 0 0", crc_o, err_o); end
    checks++; if (log_bad(0, 1'b1) !== 0) begin errors++; $display("FAIL len0_bus: %0d bad entries want 0", log_bad(0, 1'b1)); end
  endtask

  task automatic test_bus_err();
    int dc;
    viol = 0; sl_mode = 1; sl_err_at = 2;
    run_job(4, 1'b0, 1'b0, dc);
    checks++; if (err_o !== 1'b1 || crc_o !== 32'h0) begin errors++; $display("FAIL berr_result: err %b crc %h want 1 0", err_o, crc_o); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL berr_done: %0d pulse cycles want 1", dc); end
    checks++; if (log_bad(1, 1'b0) !== 0) begin errors++; $display("FAIL berr_bus: %0d bad entries want 0 (no read)", log_bad(1, 1'b0)); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL berr_drop: %0d violations want 0", viol); end
    sl_mode = 0;
  endtask

  task automatic test_timeout();
    int dc;
    sl_mode = 2;
    fork
      run_job(3, 1'b0, 1'b0, dc);
      begin
        repeat (40) @(negedge wb_clk_i);
        start_i = 1'b1; len_i = 16'd5;
        @(negedge wb_clk_i); start_i = 1'b0;
      end
    join
    repeat (3) @(negedge wb_clk_i);
    checks++; if (last_run !== 255) begin errors++; $display("FAIL tmo_len: stb held %0d cycles want 255", last_run); end
    checks++; if (err_o !== 1'b1 || dc !== 1) begin errors++; $display("FAIL tmo_result: err %b done %0d want 1 1", err_o, dc); end
    checks++; if (busy_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL tmo_restart: busy %b cyc %b want 0 0", busy_o, wbm_cyc_o); end
    sl_mode = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0, dc;
    sl_mode = 3;
    @(negedge wb_clk_i); start_i = 1'b1; len_i = 16'd2;
    @(negedge wb_clk_i); start_i = 1'b0; s_valid_i = 1'b1; s_data_i = $urandom;
    while (!(wbm_cyc_o && wbm_we_o && wbm_adr_o == 32'h0) && n < 100) begin @(negedge wb_clk_i); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL rstmid_reach: no data write after %0d cycles want <100", n); end
    repeat (3) @(negedge wb_clk_i);
    #2 wb_rst_n_i = 1'b0;
    #1;
    checks++; if ({wbm_cyc_o, wbm_stb_o, busy_o, s_ready_o} !== 4'b0) begin
      errors++; $display("FAIL rstmid_drop: cyc/stb/busy/ready %b want 0000", {wbm_cyc_o, wbm_stb_o, busy_o, s_ready_o}); end
    @(negedge wb_clk_i); wb_rst_n_i = 1'b1; s_valid_i = 1'b0; sl_mode = 0;
    run_job(2, 1'b0, 1'b0, dc);
    checks++; if (crc_o !== model_crc() || dc !== 1) begin errors++; $display("FAIL rstmid_rerun: crc %h done %0d want %h 1", crc_o, dc, model_crc()); end
  endtask

  task automatic test_back_to_back();
    int dc, len;
    logic [31:0] crc_hold;
    sl_mode = 0;
    for (int j = 0; j < 3; j++) begin
      len = $urandom_range(1, 6);
      run_job(len, j[0], 1'b0, dc);
      checks++; if (crc_o !== model_crc() || err_o !== 1'b0) begin
        errors++; $display("FAIL b2b_crc%0d: crc %h err %b want %h 0", j, crc_o, err_o, model_crc()); end
      checks++; if (log_bad(len, 1'b1) !== 0) begin errors++; $display("FAIL b2b_bus%0d: %0d bad entries want 0", j, log_bad(len, 1'b1)); end
    end
    crc_hold = model_crc();
    repeat (5) @(negedge wb_clk_i);
    checks++; if (crc_o !== crc_hold) begin errors++; $display("FAIL b2b_hold: crc %h want %h", crc_o, crc_hold); end
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_stream_toggle();
    test_len0();
    test_bus_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
